// File: rtl/fp_pkg.sv
// Shared definitions for the FP issue sequencer: FSM states, latency classes,
// exception flag positions and the instruction fields that select latency.
package fp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    CLS_BASE = 2'd0,
    CLS_MAC  = 2'd1,
    CLS_DIV  = 2'd2
  } lat_class_e;

  localparam int unsigned FLAGS_W = 5;

  localparam int unsigned FL_NV = 4;
  localparam int unsigned FL_DZ = 3;
  localparam int unsigned FL_OF = 2;
  localparam int unsigned FL_UF = 1;
  localparam int unsigned FL_NX = 0;

  localparam logic [4:0] FUNCT5_DIV  = 5'b00011;
  localparam logic [4:0] FUNCT5_SQRT = 5'b01011;

  localparam logic [6:0] OPC_FMADD  = 7'b1000011;
  localparam logic [6:0] OPC_FMSUB  = 7'b1000111;
  localparam logic [6:0] OPC_FNMSUB = 7'b1001011;
  localparam logic [6:0] OPC_FNMADD = 7'b1001111;

  function automatic logic is_fused(input logic [6:0] opcode);
    return (opcode == OPC_FMADD)  || (opcode == OPC_FMSUB) ||
           (opcode == OPC_FNMSUB) || (opcode == OPC_FNMADD);
  endfunction

endpackage

// File: rtl/fp_lat_lookup.sv
// Combinational decode of an FP instruction into its latency class and
// the counter preload (latency minus one).
module fp_lat_lookup
  import fp_pkg::*;
#(
  parameter int unsigned CNT_W    = 5,
  parameter int unsigned LAT_BASE = 1,
  parameter int unsigned LAT_MAC  = 3,
  parameter int unsigned LAT_DIV  = 12
) (
  input  logic [4:0]       funct5,
  input  logic [6:0]       opcode,
  output lat_class_e       lat_class_c,
  output logic [CNT_W-1:0] lat_m1_c
);

  // div/sqrt is keyed on funct5 alone and outranks the fused opcode match
  always_comb begin
    lat_class_c = CLS_BASE;
    lat_m1_c    = CNT_W'(LAT_BASE - 1);
    if ((funct5 == FUNCT5_DIV) || (funct5 == FUNCT5_SQRT)) begin
      lat_class_c = CLS_DIV;
      lat_m1_c    = CNT_W'(LAT_DIV - 1);
    end else if (is_fused(opcode)) begin
      lat_class_c = CLS_MAC;
      lat_m1_c    = CNT_W'(LAT_MAC - 1);
    end
  end

endmodule

// File: rtl/fp_issue_ctrl.sv
// Single-outstanding sequencer between the core pipeline and the DLFloat16 FPU:
// holds operands for the op's latency, captures result/flags, keeps sticky fflags.
module fp_issue_ctrl
  import fp_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned TAG_W    = 4,
  parameter int unsigned LAT_BASE = 1,
  parameter int unsigned LAT_MAC  = 3,
  parameter int unsigned LAT_DIV  = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [31:0]        req_instr,
  input  logic [XLEN-1:0]    req_op1,
  input  logic [XLEN-1:0]    req_op2,
  input  logic [XLEN-1:0]    req_op3,
  input  logic [TAG_W-1:0]   req_tag,
  output logic [31:0]        fpu_instr,
  output logic [XLEN-1:0]    fpu_op1,
  output logic [XLEN-1:0]    fpu_op2,
  output logic [XLEN-1:0]    fpu_op3,
  input  logic [XLEN-1:0]    fpu_result,
  input  logic [FLAGS_W-1:0] fpu_flags,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [XLEN-1:0]    rsp_result,
  output logic [FLAGS_W-1:0] rsp_flags,
  output logic [TAG_W-1:0]   rsp_tag,
  output logic [FLAGS_W-1:0] fflags,
  input  logic               fflags_clr,
  output logic               busy
);

  localparam int unsigned LAT_MAX =
    (LAT_DIV > LAT_MAC) ? ((LAT_DIV > LAT_BASE) ? LAT_DIV : LAT_BASE)
                        : ((LAT_MAC > LAT_BASE) ? LAT_MAC : LAT_BASE);
  localparam int unsigned CNT_W = $clog2(LAT_MAX) + 1;

  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [TAG_W-1:0] tag_q;
  logic             accept;
  logic             capture;
  lat_class_e       lat_cls;
  logic [CNT_W-1:0] lat_m1;
  logic             unused_cls;

  fp_lat_lookup #(
    .CNT_W    (CNT_W),
    .LAT_BASE (LAT_BASE),
    .LAT_MAC  (LAT_MAC),
    .LAT_DIV  (LAT_DIV)
  ) u_lat_lookup (
    .funct5      (req_instr[31:27]),
    .opcode      (req_instr[6:0]),
    .lat_class_c (lat_cls),
    .lat_m1_c    (lat_m1)
  );

  // class is informational here; the pipelined variant consumes it
  assign unused_cls = ^lat_cls;

  // ready is a pure function of state and rsp_ready so back-to-back issue works
  assign req_ready = (state_q == IDLE) || ((state_q == RESP) && rsp_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          accept  = 1'b1;
          cnt_d   = lat_m1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q == '0) begin
          capture = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          if (req_valid) begin
            accept  = 1'b1;
            cnt_d   = lat_m1;
            state_d = EXEC;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // datapath: operands latched on accept, response and sticky flags on capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      tag_q      <= '0;
      fpu_instr  <= '0;
      fpu_op1    <= '0;
      fpu_op2    <= '0;
      fpu_op3    <= '0;
      rsp_result <= '0;
      rsp_flags  <= '0;
      rsp_tag    <= '0;
      rsp_valid  <= 1'b0;
      busy       <= 1'b0;
      fflags     <= '0;
    end else begin
      cnt_q     <= cnt_d;
      rsp_valid <= (state_d == RESP);
      busy      <= (state_d != IDLE);
      fflags    <= (fflags_clr ? '0 : fflags) | (capture ? fpu_flags : '0);
      if (accept) begin
        fpu_instr <= req_instr;
        fpu_op1   <= req_op1;
        fpu_op2   <= req_op2;
        fpu_op3   <= req_op3;
        tag_q     <= req_tag;
      end
      if (capture) begin
        rsp_result <= fpu_result;
        rsp_flags  <= fpu_flags;
        rsp_tag    <= tag_q;
      end
    end
  end

endmodule
